// File: rtl/ps2_kbd_lock_leds_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_lock_leds_if
// Command-side link between the lock-LED manager and the PS/2 keyboard host.
//   kbd_wcmddata_o  : byte offered to the host TX FIFO (00 when no strobe)
//   kbd_enq_cmd1_o  : 1-cycle enqueue strobe for a data byte
//   kbd_enq_cmd2_o  : 1-cycle enqueue strobe for a command byte
//   kbd_stat_i      : host status (00 idle, 01 pending, FA ack, FE error)
// The master modport belongs to the lock-LED manager and the slave modport
// to the keyboard host.
// ---------------------------------------------------------------------------
interface ps2_kbd_lock_leds_if;
  logic [7:0] kbd_wcmddata_o;
  logic       kbd_enq_cmd1_o;
  logic       kbd_enq_cmd2_o;
  logic [7:0] kbd_stat_i;

  modport master (
    output kbd_wcmddata_o,
    output kbd_enq_cmd1_o,
    output kbd_enq_cmd2_o,
    input  kbd_stat_i
  );

  modport slave (
    input  kbd_wcmddata_o,
    input  kbd_enq_cmd1_o,
    input  kbd_enq_cmd2_o,
    output kbd_stat_i
  );
endinterface

// File: rtl/ps2_kbd_lock_leds.sv
// ---------------------------------------------------------------------------
// ps2_kbd_lock_leds
// Keeps the keyboard Caps/Num/Scroll Lock LEDs in step with the lock state.
// Raw set-2 scancodes are snooped to track the lock bits; whenever they change,
// the CPU overrides them, or the keyboard reports a BAT, the block sends
// ED + LED byte to the keyboard host, with ACK/ERR/timeout handling and a
// bounded number of retries.
//
// Ports:
//   clk6x          : 48 MHz clock
//   resetn         : asynchronous active-low reset
//   ck1us          : single-cycle 1 us tick
//   enable_i       : 0 = keep tracking, but do not start new sends
//   snoop_code_i   : raw scancode from the PS/2 port
//   snoop_valid_i  : strobe qualifying snoop_code_i
//   kbd_bat_ok_i   : keyboard BAT-OK received strobe
//   cpu_leds_i     : CPU-written LED value
//   cpu_leds_we_i  : load cpu_leds_i into leds_o
//   host           : command link to the keyboard host (master side)
//   leds_o         : bit0 Scroll, bit1 Num, bit2 Caps
//   busy_o         : a send sequence is in progress
//   fail_o         : sticky, retries exhausted; cleared by the next ACK
// ---------------------------------------------------------------------------
module ps2_kbd_lock_leds #(
  parameter int unsigned TIMEOUT_US  = 20000,
  parameter int unsigned HOLDOFF_US  = 1000,
  parameter int unsigned MAX_RETRIES = 3,
  parameter logic [2:0]  LED_INIT    = 3'b000
) (
  input  logic                       clk6x,
  input  logic                       resetn,
  input  logic                       ck1us,
  input  logic                       enable_i,
  input  logic [7:0]                 snoop_code_i,
  input  logic                       snoop_valid_i,
  input  logic                       kbd_bat_ok_i,
  input  logic [2:0]                 cpu_leds_i,
  input  logic                       cpu_leds_we_i,
  ps2_kbd_lock_leds_if.master        host,
  output logic [2:0]                 leds_o,
  output logic                       busy_o,
  output logic                       fail_o
);

  localparam logic [7:0]  CMD_SET_LEDS = 8'hED;
  localparam logic [7:0]  STAT_PENDING = 8'h01;
  localparam logic [7:0]  STAT_ACK     = 8'hFA;
  localparam logic [7:0]  STAT_ERR     = 8'hFE;
  localparam logic [14:0] TIMER_MAX    = 15'h7FFF;
  localparam logic [14:0] TIMEOUT_C    = 15'(TIMEOUT_US);
  localparam logic [14:0] HOLDOFF_C    = 15'(HOLDOFF_US);
  localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_DATA,
    S_WAIT,
    S_HOLDOFF
  } state_e;

  state_e      state_q;
  logic [2:0]  leds_q, leds_d;
  logic [2:0]  held_q, held_d;
  logic        f0_q, f0_d;
  logic        e0_q, e0_d;
  logic [2:0]  skip_q, skip_d;
  logic        dirty_q;
  logic        fail_q;
  logic [14:0] timer_q;
  logic [7:0]  retries_q;
  logic [7:0]  wdata_q;
  logic        enq1_q;
  logic        enq2_q;

  logic [2:0]  lock_mask;
  logic        snoop_toggle;
  logic        mark_dirty;

  // Scancode snoop: prefix tracking, Pause-sequence skipping and make/break
  // handling of the three lock keys. A CPU write overrides a same-cycle toggle.
  always_comb begin
    leds_d       = leds_q;
    held_d       = held_q;
    f0_d         = f0_q;
    e0_d         = e0_q;
    skip_d       = skip_q;
    snoop_toggle = 1'b0;
    lock_mask    = 3'b000;

    case (snoop_code_i)
      8'h58:   lock_mask = 3'b100;
      8'h77:   lock_mask = 3'b010;
      8'h7E:   lock_mask = 3'b001;
      default: lock_mask = 3'b000;
    endcase

    if (snoop_valid_i) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (snoop_code_i == 8'hE1) begin
        // The Pause key sends E1 followed by seven more bytes, one of which
        // is 77; swallowing them keeps NumLock untouched.
        skip_d = 3'd7;
        f0_d   = 1'b0;
        e0_d   = 1'b0;
      end else if (snoop_code_i == 8'hF0) begin
        f0_d = 1'b1;
      end else if (snoop_code_i == 8'hE0) begin
        e0_d = 1'b1;
      end else if (snoop_code_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                        8'hFC, 8'hFE, 8'hFF}) begin
        // Keyboard replies and error codes, not key events.
      end else begin
        if (!e0_q && (lock_mask != 3'b000)) begin
          if (f0_q) begin
            held_d = held_q & ~lock_mask;
          end else if ((held_q & lock_mask) == 3'b000) begin
            // Only the first make toggles; typematic repeats keep held set.
            leds_d       = leds_q ^ lock_mask;
            held_d       = held_q | lock_mask;
            snoop_toggle = 1'b1;
          end
        end
        f0_d = 1'b0;
        e0_d = 1'b0;
      end
    end

    if (cpu_leds_we_i) begin
      leds_d = cpu_leds_i;
    end
    if (kbd_bat_ok_i) begin
      held_d = 3'b000;
    end

    mark_dirty = snoop_toggle | cpu_leds_we_i | kbd_bat_ok_i;
  end

  // Send sequencer. Strobes and the command byte are registered so each is
  // valid for exactly the one cycle the FSM spends in SEND_CMD / SEND_DATA.
  // The data byte captured on leaving SEND_CMD is the LED snapshot for this
  // attempt; later changes only re-arm dirty.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      leds_q    <= LED_INIT;
      held_q    <= 3'b000;
      f0_q      <= 1'b0;
      e0_q      <= 1'b0;
      skip_q    <= 3'd0;
      dirty_q   <= 1'b1;
      fail_q    <= 1'b0;
      timer_q   <= 15'd0;
      retries_q <= 8'd0;
      wdata_q   <= 8'h00;
      enq1_q    <= 1'b0;
      enq2_q    <= 1'b0;
    end else begin
      leds_q <= leds_d;
      held_q <= held_d;
      f0_q   <= f0_d;
      e0_q   <= e0_d;
      skip_q <= skip_d;
      enq1_q  <= 1'b0;
      enq2_q  <= 1'b0;
      wdata_q <= 8'h00;
      if (mark_dirty) begin
        dirty_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (dirty_q && enable_i && (host.kbd_stat_i != STAT_PENDING)) begin
            state_q <= S_SEND_CMD;
            enq2_q  <= 1'b1;
            wdata_q <= CMD_SET_LEDS;
          end
        end

        S_SEND_CMD: begin
          // A dirty-setting event in this very cycle must survive the clear.
          if (!mark_dirty) begin
            dirty_q <= 1'b0;
          end
          enq1_q  <= 1'b1;
          wdata_q <= {5'b00000, leds_q};
          state_q <= S_SEND_DATA;
        end

        S_SEND_DATA: begin
          timer_q <= 15'd0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (ck1us && (timer_q != TIMER_MAX)) begin
            timer_q <= timer_q + 15'd1;
          end
          if (host.kbd_stat_i == STAT_ACK) begin
            fail_q    <= 1'b0;
            retries_q <= 8'd0;
            state_q   <= S_IDLE;
          end else if ((host.kbd_stat_i == STAT_ERR) || (timer_q >= TIMEOUT_C)) begin
            if (retries_q < RETRY_LIMIT) begin
              retries_q <= retries_q + 8'd1;
              timer_q   <= 15'd0;
              state_q   <= S_HOLDOFF;
            end else begin
              fail_q    <= 1'b1;
              retries_q <= 8'd0;
              state_q   <= S_IDLE;
            end
          end
        end

        S_HOLDOFF: begin
          if (timer_q >= HOLDOFF_C) begin
            dirty_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (ck1us && (timer_q != TIMER_MAX)) begin
            timer_q <= timer_q + 15'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign host.kbd_wcmddata_o = wdata_q;
  assign host.kbd_enq_cmd1_o = enq1_q;
  assign host.kbd_enq_cmd2_o = enq2_q;
  assign leds_o              = leds_q;
  assign busy_o              = (state_q != S_IDLE);
  assign fail_o              = fail_q;

endmodule

// File: tb/tb_ps2_kbd_lock_leds.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_lock_leds
// Bench for ps2_kbd_lock_leds: a small keyboard-host model answers each
// ED/xx sequence (ACK, ERR or silence), and a scancode-level model of the
// lock keys predicts the LED state and the data byte of every send.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_kbd_lock_leds;
  localparam int         TIMEOUT_T = 30;
  localparam int         HOLDOFF_T = 8;
  localparam int         RETRIES_T = 3;
  localparam logic [2:0] INIT_T    = 3'b000;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       ck1us = 1'b0;
  logic       enable_i = 1'b1;
  logic [7:0] snoop_code_i = 8'h00;
  logic       snoop_valid_i = 1'b0;
  logic       kbd_bat_ok_i = 1'b0;
  logic [2:0] cpu_leds_i = 3'b000;
  logic       cpu_leds_we_i = 1'b0;
  logic [2:0] leds_o;
  logic       busy_o;
  logic       fail_o;

  ps2_kbd_lock_leds_if hostIf();

  ps2_kbd_lock_leds #(
    .TIMEOUT_US (TIMEOUT_T),
    .HOLDOFF_US (HOLDOFF_T),
    .MAX_RETRIES(RETRIES_T),
    .LED_INIT   (INIT_T)
  ) dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .ck1us        (ck1us),
    .enable_i     (enable_i),
    .snoop_code_i (snoop_code_i),
    .snoop_valid_i(snoop_valid_i),
    .kbd_bat_ok_i (kbd_bat_ok_i),
    .cpu_leds_i   (cpu_leds_i),
    .cpu_leds_we_i(cpu_leds_we_i),
    .host         (hostIf.master),
    .leds_o       (leds_o),
    .busy_o       (busy_o),
    .fail_o       (fail_o)
  );

  always #5 clk6x = ~clk6x;

  int total = 0;
  int bad = 0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // 1 us tick: one cycle in four.
  int divCount = 0;
  int tickCount = 0;
  always @(negedge clk6x) begin
    divCount = (divCount == 3) ? 0 : divCount + 1;
    ck1us = (divCount == 3);
    if (ck1us) tickCount++;
  end

  // Keyboard host model: logs sends and replies after ackDelay cycles.
  logic [7:0] kbdStat = 8'h00;
  logic [7:0] pendingReply = 8'h00;
  logic [7:0] sentData[$];
  int         cmdTick[$];
  int         dropReplies = 0;
  int         errReplies = 0;
  int         ackDelay = 5;
  int         replyTimer = 0;
  int         hostCycle = 0;
  int         lastCmdCycle = -10;
  assign hostIf.kbd_stat_i = kbdStat;

  always @(negedge clk6x) begin
    hostCycle++;
    if (!resetn) begin
      kbdStat = 8'h00;
      replyTimer = 0;
    end else begin
      if (replyTimer > 0) begin
        replyTimer--;
        if (replyTimer == 0) kbdStat = pendingReply;
      end
      if (hostIf.kbd_enq_cmd2_o) begin
        checkOutput("cmd2-byte", hostIf.kbd_wcmddata_o, 8'hED);
        checkOutput("cmd2-alone", hostIf.kbd_enq_cmd1_o, 0);
        lastCmdCycle = hostCycle;
        cmdTick.push_back(tickCount);
        kbdStat = 8'h01;
      end else if (hostIf.kbd_enq_cmd1_o) begin
        checkOutput("cmd1-after-cmd2", hostCycle - lastCmdCycle, 1);
        sentData.push_back(hostIf.kbd_wcmddata_o);
        kbdStat = 8'h01;
        if (dropReplies > 0) begin
          dropReplies--;
          pendingReply = 8'h00;
        end else if (errReplies > 0) begin
          errReplies--;
          pendingReply = 8'hFE;
        end else begin
          pendingReply = 8'hFA;
        end
        replyTimer = ackDelay;
      end else begin
        checkOutput("wdata-idle", hostIf.kbd_wcmddata_o, 8'h00);
      end
    end
  end

  // Reference model of the lock keys, working byte by byte on the scancode
  // stream as a keyboard user would describe it.
  logic [2:0] mLeds = INIT_T;
  logic [2:0] mHeld = 3'b000;
  bit         mBreak = 0;
  bit         mExt = 0;
  int         mSkip = 0;
  int         pendingToggles = 0;

  function automatic int modelByte(input logic [7:0] code);
    int keyBit;
    if (mSkip > 0) begin
      mSkip--;
      return 0;
    end
    if (code == 8'hE1) begin
      mSkip = 7; mBreak = 0; mExt = 0;
      return 0;
    end
    if (code == 8'hF0) begin
      mBreak = 1;
      return 0;
    end
    if (code == 8'hE0) begin
      mExt = 1;
      return 0;
    end
    if (code == 8'h00 || code == 8'hAA || code == 8'hEE || code == 8'hFA ||
        code == 8'hFC || code == 8'hFE || code == 8'hFF) return 0;
    keyBit = (code == 8'h58) ? 2 : (code == 8'h77) ? 1 : (code == 8'h7E) ? 0 : -1;
    if (keyBit >= 0 && !mExt) begin
      if (mBreak) begin
        mHeld[keyBit] = 1'b0;
      end else if (!mHeld[keyBit]) begin
        mLeds[keyBit] = ~mLeds[keyBit];
        mHeld[keyBit] = 1'b1;
        mBreak = 0; mExt = 0;
        return 1;
      end
    end
    mBreak = 0; mExt = 0;
    return 0;
  endfunction

  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clk6x);
    snoop_code_i = code;
    snoop_valid_i = 1'b1;
    pendingToggles += modelByte(code);
    @(negedge clk6x);
    snoop_valid_i = 1'b0;
    snoop_code_i = 8'h00;
    repeat (2) @(negedge clk6x);
  endtask

  // Idle means busy_o low for several consecutive cycles, since the FSM
  // passes through IDLE for one cycle between a holdoff and the retry.
  task automatic waitIdle();
    int quiet = 0;
    int spent = 0;
    repeat (3) @(negedge clk6x);
    while (quiet < 6 && spent < 4000) begin
      @(negedge clk6x);
      spent++;
      quiet = busy_o ? 0 : quiet + 1;
    end
    checkOutput("idle-within-budget", (spent < 4000), 1);
  endtask

  int sentBase = 0;
  task automatic checkSends(input string tag, input int expCount);
    waitIdle();
    checkOutput({tag, "-count"}, sentData.size() - sentBase, expCount);
    if (expCount > 0 && sentData.size() > 0)
      checkOutput({tag, "-data"}, sentData[$], {5'b00000, mLeds});
    checkOutput({tag, "-leds"}, leds_o, mLeds);
    sentBase = sentData.size();
    pendingToggles = 0;
  endtask

  task automatic waitSends(input string tag, input int count);
    int spent = 0;
    while (sentData.size() < sentBase + count && spent < 2000) begin
      @(negedge clk6x);
      spent++;
    end
    checkOutput(tag, (sentData.size() >= sentBase + count), 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0] lockCodes [3] = '{8'h58, 8'h77, 8'h7E};
  logic [7:0] quietCodes [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  initial begin
    int cmdBase;
    int pick;
    logic [7:0] code;

    // Reset state
    repeat (4) @(negedge clk6x);
    checkOutput("rst-leds", leds_o, INIT_T);
    checkOutput("rst-busy", busy_o, 0);
    checkOutput("rst-fail", fail_o, 0);
    checkOutput("rst-enq1", hostIf.kbd_enq_cmd1_o, 0);
    checkOutput("rst-enq2", hostIf.kbd_enq_cmd2_o, 0);
    checkOutput("rst-wdata", hostIf.kbd_wcmddata_o, 8'h00);

    // Initial sync out of reset: ED/00 then ACK
    @(negedge clk6x);
    resetn = 1'b1;
    checkSends("boot", 1);
    checkOutput("boot-busy", busy_o, 0);

    // Caps make, typematic repeats, break, make-while-released toggles once
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    checkSends("caps", 1);
    checkOutput("caps-value", leds_o, 3'b100);

    // Pause sequence must not touch NumLock
    applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77);
    applyStimulus(8'hE1); applyStimulus(8'hF0); applyStimulus(8'h14);
    applyStimulus(8'hF0); applyStimulus(8'h77);
    checkSends("pause", 0);
    applyStimulus(8'h77); applyStimulus(8'hF0); applyStimulus(8'h77);
    checkSends("num", 1);

    // Error on every attempt: first try plus three retries, then fail
    errReplies = 4;
    cmdBase = cmdTick.size();
    applyStimulus(8'h7E);
    applyStimulus(8'hF0);
    applyStimulus(8'h7E);
    checkSends("err", 4);
    checkOutput("err-fail", fail_o, 1);
    checkOutput("err-busy", busy_o, 0);
    checkOutput("err-attempts", cmdTick.size() - cmdBase, 4);
    for (int i = cmdBase + 1; i < cmdTick.size(); i++)
      checkOutput("err-holdoff-gap", (cmdTick[i] - cmdTick[i-1] >= HOLDOFF_T), 1);

    // Timeout then ACKed retry; Scroll press during the retry's wait
    dropReplies = 1;
    ackDelay = 20;
    applyStimulus(8'h58);
    waitSends("retry-seen", 2);
    applyStimulus(8'h7E);
    checkSends("timeout", 3);
    checkOutput("timeout-fail-cleared", fail_o, 0);
    ackDelay = 5;
    applyStimulus(8'hF0); applyStimulus(8'h58);
    applyStimulus(8'hF0); applyStimulus(8'h7E);
    checkSends("release", 0);

    // BAT resends the current LEDs and forgets held keys
    applyStimulus(8'h58);
    checkSends("pre-bat", 1);
    @(negedge clk6x);
    kbd_bat_ok_i = 1'b1;
    mHeld = 3'b000;
    @(negedge clk6x);
    kbd_bat_ok_i = 1'b0;
    checkSends("bat", 1);
    applyStimulus(8'h58);
    checkSends("after-bat", 1);
    applyStimulus(8'hF0); applyStimulus(8'h58);
    checkSends("after-bat-rel", 0);

    // CPU write wins over a same-cycle Caps make
    @(negedge clk6x);
    snoop_code_i = 8'h58;
    snoop_valid_i = 1'b1;
    cpu_leds_i = 3'b001;
    cpu_leds_we_i = 1'b1;
    void'(modelByte(8'h58));
    mLeds = 3'b001;
    @(negedge clk6x);
    snoop_valid_i = 1'b0;
    cpu_leds_we_i = 1'b0;
    checkSends("cpu", 1);
    checkOutput("cpu-value", leds_o, 3'b001);
    applyStimulus(8'hF0); applyStimulus(8'h58);
    checkSends("cpu-rel", 0);

    // Disabled: tracking continues, send waits for enable
    enable_i = 1'b0;
    applyStimulus(8'h7E);
    checkSends("disabled", 0);
    enable_i = 1'b1;
    checkSends("enabled", 1);
    applyStimulus(8'hF0); applyStimulus(8'h7E);
    checkSends("enabled-rel", 0);

    // Reset in the middle of a wait
    dropReplies = 1;
    applyStimulus(8'h77);
    waitSends("pre-reset-send", 1);
    repeat (3) @(negedge clk6x);
    resetn = 1'b0;
    #1;
    checkOutput("midrst-leds", leds_o, INIT_T);
    checkOutput("midrst-busy", busy_o, 0);
    checkOutput("midrst-fail", fail_o, 0);
    checkOutput("midrst-enq", {hostIf.kbd_enq_cmd2_o, hostIf.kbd_enq_cmd1_o}, 0);
    checkOutput("midrst-wdata", hostIf.kbd_wcmddata_o, 8'h00);
    mLeds = INIT_T; mHeld = 3'b000; mBreak = 0; mExt = 0; mSkip = 0;
    repeat (3) @(negedge clk6x);
    resetn = 1'b1;
    sentBase = sentData.size();
    checkSends("post-reset", 1);

    // Random scancode traffic, one byte at a time
    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 2)      code = lockCodes[$urandom_range(0, 2)];
      else if (pick <= 4) code = 8'hF0;
      else if (pick == 5) code = 8'hE0;
      else if (pick == 6) code = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
      else if (pick == 7) code = quietCodes[$urandom_range(0, 6)];
      else                code = 8'($urandom_range(1, 127));
      applyStimulus(code);
      checkSends("rand", pendingToggles);
    end
    checkOutput("final-fail", fail_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
